arb_bus_memory: RTL and testbench
=================================

Name: arb_bus_memory

Overview:
- Parametrised successor to the single-initiator toggle-handshake memory used by the tiny CPU.
- Serves NUM_PORTS independent bus initiators, for example CPU instruction fetch, CPU data access and a debug/DMA master.
- Uses round-robin arbitration, configurable data width and depth, programmable wait states, and a per-port out-of-range error flag.
- Keeps the existing command encoding and run/done toggle protocol, so current initiators connect unchanged.

Parameters:
- DATA_W, 16: word width in bits; multiple of 8, minimum 16.
- ADDR_W, 16: byte-address width.
- DEPTH, 32768: number of words implemented.
- NUM_PORTS, 2: number of initiator ports; range 1..8.
- WAIT_STATES, 0: extra cycles inserted between grant and access; range 0..15.

Ports:
- clk, in, 1: single clock, all logic on posedge.
- reset, in, 1: asynchronous, active-high reset.
- run, in, NUM_PORTS: per-port request toggle; a request is pending while run[i] != done[i].
- cmd, in, 2*NUM_PORTS: per-port command. 00 = read word, 01 = write word, 10 = read byte, 11 = write byte.
- addr, in, ADDR_W*NUM_PORTS: per-port byte address.
- wr_data, in, DATA_W*NUM_PORTS: per-port write data; byte writes use bits [7:0].
- rd_data, out, DATA_W*NUM_PORTS: per-port read data, registered.
- done, out, NUM_PORTS: per-port completion toggle.
- err, out, NUM_PORTS: per-port flag; 1 if the last completed access was out of range.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous):
  - done, err, rd_data all 0; busy 0.
  - FSM goes to IDLE; round-robin pointer goes to 0.
  - Memory contents are not cleared.
- Reset mid-access:
  - The in-flight access is aborted and no write occurs.
  - Initiators must also reset run to 0, otherwise their request is seen as pending again.
- Addressing:
  - L = log2(DATA_W/8).
  - Word index = addr[ADDR_W-1:L]; byte lane = addr[L-1:0]; for DATA_W = 16, byte lane = addr[0].
- Byte read: rd_data = {zeros, selected lane byte}.
- Byte write: updates only the selected lane; other lanes are preserved.
- Word access: ignores the lane bits.
- Out-of-range access (word index >= DEPTH):
  - Writes are dropped.
  - Reads return 0.
  - err[p] is set to 1 at completion.
  - Any in-range completion clears err[p].
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: if any request is pending, grant the first pending port scanning from the pointer upward with wrap. At grant, latch port index, cmd, addr and wr_data. Go to WAIT if WAIT_STATES > 0, else ACCESS. With no pending requests, stay in IDLE.
  - WAIT: count down WAIT_STATES cycles, then go to ACCESS.
  - ACCESS:
    - Perform the memory operation.
    - Update rd_data[p] on reads only; it holds otherwise.
    - Update err[p].
    - Toggle done[p] on the same edge.
    - Set pointer = (p + 1) mod NUM_PORTS and return to IDLE.
- Latency: run toggle sampled at edge N leads to done toggle at edge N + 1 + WAIT_STATES. Throughput is one access per 2 + WAIT_STATES cycles.
- Simultaneous requests are served strictly round-robin; no port waits more than NUM_PORTS - 1 other accesses.
- Initiators must hold cmd, addr and wr_data stable and must not toggle run while their request is pending. Values are captured at grant, so post-grant changes have no effect on the current access.
- rd_data is valid when done[p] == run[p] and holds until that port's next read completes.

Test Plan:
1. Single-port word round trip (WAIT_STATES=0): port0 writes 0x1234 to addr 0x0040, then reads addr 0x0040 -> rd_data0 = 0x1234; each done0 toggles exactly 2 edges after its run toggle; err0 = 0.
2. Byte lanes: word at addr 0x0040 holds 0x1234; write byte 0xAB to addr 0x0041 -> word read gives 0xAB34; byte read of addr 0x0040 gives 0x0034.
3. Contention: port0 and port1 both toggle run on the same edge with pointer 0 -> port0 completes first, port1 completes 2 cycles later. Repeating the contention then serves port1 first.
4. Wait states (WAIT_STATES=3): port0 read -> done0 toggles 5 edges after run0; busy is high for 4 cycles.
5. Out of range (DEPTH=1024): port1 write 0xBEEF to addr 0x0800 -> no memory change, err1 = 1. A following read of addr 0x0800 -> rd_data1 = 0, err1 = 1. A following in-range read -> err1 = 0.
6. Asynchronous reset asserted during WAIT of a write to addr 0x0010 (old value 0x5555) -> done, err and rd_data go to 0 immediately; a later read of addr 0x0010 returns 0x5555.

Source files
------------

// File: rtl/arb_bus_memory.sv
// Multi-port word/byte memory using the run/done toggle handshake.
// Pending requests are granted round-robin, with optional wait states before each access.
module arb_bus_memory #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 32768,
    parameter int NUM_PORTS   = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        run,
    input  logic [2*NUM_PORTS-1:0]      cmd,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr,
    input  logic [DATA_W*NUM_PORTS-1:0] wr_data,
    output logic [DATA_W*NUM_PORTS-1:0] rd_data,
    output logic [NUM_PORTS-1:0]        done,
    output logic [NUM_PORTS-1:0]        err,
    output logic                        busy
);
    localparam int LANE_W = $clog2(DATA_W / 8);
    localparam int IDX_W  = ADDR_W - LANE_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0] pending;
    logic [PW-1:0]        ptr, gnt_port, lat_port, next_ptr;
    logic                 gnt_vld, grant, do_access;
    logic [1:0]           lat_cmd;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic [3:0]           wait_cnt;
    logic [IDX_W-1:0]     word_idx;
    logic [LANE_W-1:0]    lane;
    logic [MEM_AW-1:0]    mem_idx;
    logic                 in_range;
    logic [DATA_W-1:0]    mem_word, wr_word, rd_word;

    assign pending  = run ^ done;
    assign word_idx = lat_addr[ADDR_W-1:LANE_W];
    assign lane     = lat_addr[LANE_W-1:0];
    assign mem_idx  = MEM_AW'(word_idx);
    assign in_range = (32'(word_idx) < 32'(DEPTH));
    assign mem_word = mem[mem_idx];
    assign next_ptr = (lat_port == PW'(NUM_PORTS - 1)) ? '0 : lat_port + 1'b1;

    // Descending scan so the port closest above the pointer wins.
    always_comb begin
        int j;
        j        = 0;
        gnt_vld  = 1'b0;
        gnt_port = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_PORTS;
            if (pending[j]) begin
                gnt_vld  = 1'b1;
                gnt_port = PW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (gnt_vld) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (wait_cnt == 4'd0) state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        grant     = (state == S_IDLE) && gnt_vld;
        do_access = (state == S_ACCESS);
    end

    // Byte writes merge into the current word; reads zero-extend the selected lane.
    always_comb begin
        wr_word = lat_wdata;
        if (lat_cmd[1]) begin
            wr_word = mem_word;
            wr_word[{lane, 3'b000} +: 8] = lat_wdata[7:0];
        end
        rd_word = '0;
        if (in_range)
            rd_word = lat_cmd[1] ? DATA_W'(mem_word[{lane, 3'b000} +: 8]) : mem_word;
    end

    always_ff @(posedge clk) begin
        if (do_access && lat_cmd[0] && in_range)
            mem[mem_idx] <= wr_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_port  <= '0;
            lat_cmd   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
        end else if (grant) begin
            lat_port  <= gnt_port;
            lat_cmd   <= cmd[2*gnt_port +: 2];
            lat_addr  <= addr[ADDR_W*gnt_port +: ADDR_W];
            lat_wdata <= wr_data[DATA_W*gnt_port +: DATA_W];
            wait_cnt  <= WAIT_LOAD;
        end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            done    <= '0;
            err     <= '0;
            rd_data <= '0;
        end else if (do_access) begin
            done[lat_port] <= ~done[lat_port];
            err[lat_port]  <= ~in_range;
            if (!lat_cmd[0])
                rd_data[DATA_W*lat_port +: DATA_W] <= rd_word;
            ptr <= next_ptr;
        end
    end
endmodule

// File: tb/tb_arb_bus_memory.sv
// Scoreboard bench: two instances (0 and 3 wait states) sharing one clock.
// Expected completions are queued at issue time and popped by a monitor on each done toggle.
module tb_arb_bus_memory;
    localparam logic [1:0] RW = 2'b00, WW = 2'b01, RB = 2'b10, WB = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_v  [2];
    logic [1:0]  run_v  [2];
    logic [3:0]  cmd_v  [2];
    logic [31:0] addr_v [2];
    logic [31:0] wd_v   [2];
    logic [31:0] rd_v   [2];
    logic [1:0]  done_v [2];
    logic [1:0]  err_v  [2];
    logic        busy_v [2];

    arb_bus_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .NUM_PORTS(2), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_v[0]), .run(run_v[0]), .cmd(cmd_v[0]), .addr(addr_v[0]),
        .wr_data(wd_v[0]), .rd_data(rd_v[0]), .done(done_v[0]), .err(err_v[0]), .busy(busy_v[0]));

    arb_bus_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .NUM_PORTS(2), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst_v[1]), .run(run_v[1]), .cmd(cmd_v[1]), .addr(addr_v[1]),
        .wr_data(wd_v[1]), .rd_data(rd_v[1]), .done(done_v[1]), .err(err_v[1]), .busy(busy_v[1]));

    typedef struct {
        int          port;
        logic [15:0] data;
        bit          chk_data;
        logic        err;
        int          exp_edge;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at a negedge; the request is sampled on the next posedge.
    task automatic issue(input int d, input int p, input logic [1:0] c, input logic [15:0] a,
                         input logic [15:0] w, input logic [15:0] exp_d, input bit chk,
                         input logic exp_e, input int lat, input bit push);
        exp_t e;
        cmd_v[d][2*p +: 2]   = c;
        addr_v[d][16*p +: 16] = a;
        wd_v[d][16*p +: 16]   = w;
        run_v[d][p]           = ~run_v[d][p];
        e.port = p; e.data = exp_d; e.chk_data = chk; e.err = exp_e; e.exp_edge = cyc + 1 + lat;
        if (push) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic wait_drain(input int d);
        for (int i = 0; i < 40; i++) begin
            if (((d == 0) ? q0.size() : q1.size()) == 0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL drain timeout dut%0d: %0d completions outstanding, expected 0",
                 d, (d == 0) ? q0.size() : q1.size());
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic op(input int d, input int p, input logic [1:0] c, input logic [15:0] a,
                      input logic [15:0] w, input logic [15:0] exp_d, input logic exp_e);
        @(negedge clk);
        issue(d, p, c, a, w, exp_d, !c[0], exp_e, (d == 0) ? 1 : 4, 1'b1);
        wait_drain(d);
    endtask

    task automatic monitor();
        logic [1:0] prev [2];
        exp_t e;
        prev[0] = done_v[0];
        prev[1] = done_v[1];
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_v[d]) begin
                    prev[d] = done_v[d];
                    continue;
                end
                for (int p = 0; p < 2; p++) begin
                    if (done_v[d][p] !== prev[d][p]) begin
                        if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected done dut%0d p%0d: got toggle expected none", d, p);
                        end else begin
                            if (d == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            check($sformatf("dut%0d order", d), p, e.port);
                            check($sformatf("dut%0d p%0d done edge", d, p), cyc, e.exp_edge);
                            check($sformatf("dut%0d p%0d err", d, p), 32'(err_v[d][p]), 32'(e.err));
                            if (e.chk_data)
                                check($sformatf("dut%0d p%0d rd_data", d, p), 32'(rd_v[d][16*p +: 16]), 32'(e.data));
                        end
                    end
                end
                prev[d] = done_v[d];
            end
        end
    endtask

    initial begin
        rst_v  = '{1'b1, 1'b1};
        run_v  = '{2'b00, 2'b00};
        cmd_v  = '{4'h0, 4'h0};
        addr_v = '{32'h0, 32'h0};
        wd_v   = '{32'h0, 32'h0};
        repeat (3) @(negedge clk);
        rst_v = '{1'b0, 1'b0};
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset done", d), 32'(done_v[d]), 32'h0);
            check($sformatf("dut%0d reset err", d), 32'(err_v[d]), 32'h0);
            check($sformatf("dut%0d reset rd_data", d), rd_v[d], 32'h0);
            check($sformatf("dut%0d reset busy", d), 32'(busy_v[d]), 32'h0);
        end

        fork
            monitor();
        join_none

        // Word round trip, byte lanes
        op(0, 0, WW, 16'h0000, 16'h7777, 16'h0000, 1'b0);
        op(0, 0, WW, 16'h0040, 16'h1234, 16'h0000, 1'b0);
        op(0, 0, RW, 16'h0040, 16'h0000, 16'h1234, 1'b0);
        op(0, 0, WB, 16'h0041, 16'h00AB, 16'h0000, 1'b0);
        op(0, 0, RW, 16'h0040, 16'h0000, 16'hAB34, 1'b0);
        op(0, 0, RB, 16'h0040, 16'h0000, 16'h0034, 1'b0);
        op(0, 0, RB, 16'h0041, 16'h0000, 16'h00AB, 1'b0);
        op(0, 1, RW, 16'h0040, 16'h0000, 16'hAB34, 1'b0);

        // Contention with pointer 0: port0 first, port1 two cycles later
        @(negedge clk);
        issue(0, 0, RW, 16'h0040, 16'h0, 16'hAB34, 1, 1'b0, 1, 1'b1);
        issue(0, 1, RB, 16'h0041, 16'h0, 16'h00AB, 1, 1'b0, 3, 1'b1);
        wait_drain(0);

        // Pointer moved to 1: contention now serves port1 first
        op(0, 0, RB, 16'h0040, 16'h0000, 16'h0034, 1'b0);
        @(negedge clk);
        issue(0, 1, RB, 16'h0040, 16'h0, 16'h0034, 1, 1'b0, 1, 1'b1);
        issue(0, 0, RW, 16'h0000, 16'h0, 16'h7777, 1, 1'b0, 3, 1'b1);
        wait_drain(0);

        // Out of range: word index 0x400 == DEPTH
        op(0, 1, WW, 16'h0800, 16'hBEEF, 16'h0000, 1'b1);
        op(0, 1, RW, 16'h0800, 16'h0000, 16'h0000, 1'b1);
        op(0, 0, RW, 16'h0000, 16'h0000, 16'h7777, 1'b0);
        op(0, 1, RW, 16'h0040, 16'h0000, 16'hAB34, 1'b0);

        // Wait states: busy spans 3 WAIT cycles plus ACCESS
        op(1, 0, WW, 16'h0010, 16'h5555, 16'h0000, 1'b0);
        @(negedge clk);
        issue(1, 0, RW, 16'h0010, 16'h0, 16'h5555, 1, 1'b0, 4, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("ws3 busy k=%0d", k), 32'(busy_v[1]), (k <= 4) ? 32'h1 : 32'h0);
        end
        wait_drain(1);
        op(1, 1, RW, 16'h0800, 16'h0000, 16'h0000, 1'b1);

        // Reset during WAIT of a write aborts it
        @(negedge clk);
        issue(1, 0, WW, 16'h0010, 16'h0000, 16'h0, 0, 1'b0, 4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_v[1] = 1'b1;
        run_v[1] = 2'b00;
        #1;
        check("midreset done", 32'(done_v[1]), 32'h0);
        check("midreset err", 32'(err_v[1]), 32'h0);
        check("midreset rd_data", rd_v[1], 32'h0);
        check("midreset busy", 32'(busy_v[1]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_v[1] = 1'b0;
        op(1, 0, RW, 16'h0010, 16'h0000, 16'h5555, 1'b0);

        repeat (3) @(negedge clk);
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
